// File: rtl/frequency_generator.sv
// Phase-accumulator square-wave source with continuous or N-period burst output.
// Tuning-word changes take effect only at a period boundary so no runt pulses appear.
module frequency_generator #(
  parameter int ACC_WIDTH   = 32,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                   iclk,
  input  logic                   reset,
  input  logic [ACC_WIDTH-1:0]   tuning_word,
  input  logic                   load,
  input  logic [COUNT_WIDTH-1:0] burst_count,
  input  logic                   start,
  input  logic                   stop,
  output logic                   out,
  output logic                   busy,
  output logic                   interrupt,
  input  logic                   interrupt_clear
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   active_tw;
  logic [ACC_WIDTH-1:0]   pending_tw;
  logic                   pending_valid;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   burst_mode;

  logic [ACC_WIDTH:0]     sum;
  logic                   carry;
  logic                   tw_zero;
  logic                   last_period;

  assign sum         = {1'b0, acc} + {1'b0, active_tw};
  assign carry       = sum[ACC_WIDTH];
  assign tw_zero     = (active_tw == '0);
  assign last_period = burst_mode && (remaining == COUNT_WIDTH'(1));

  assign out  = acc[ACC_WIDTH-1];
  assign busy = (state != IDLE);

  always_ff @(posedge iclk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      acc           <= '0;
      active_tw     <= '0;
      pending_tw    <= '0;
      pending_valid <= 1'b0;
      remaining     <= '0;
      burst_mode    <= 1'b0;
      interrupt     <= 1'b0;
    end else begin
      // Clear first so a burst completion later in this block wins.
      if (interrupt_clear) interrupt <= 1'b0;

      case (state)
        IDLE: begin
          acc <= '0;
          if (load) pending_tw <= tuning_word;
          if (start) begin
            active_tw     <= load ? tuning_word : pending_tw;
            remaining     <= burst_count;
            burst_mode    <= (burst_count != '0);
            pending_valid <= 1'b0;
            state         <= RUN;
          end
        end

        RUN, STOPPING: begin
          if (tw_zero) begin
            // No carry can ever arrive, so word changes and stop act immediately.
            if (load) begin
              pending_tw    <= tuning_word;
              pending_valid <= 1'b1;
            end else if (pending_valid) begin
              active_tw     <= pending_tw;
              pending_valid <= 1'b0;
            end
            if (stop || state == STOPPING) begin
              state <= IDLE;
              acc   <= '0;
            end
          end else if (carry) begin
            if (load) begin
              active_tw     <= tuning_word;
              pending_valid <= 1'b0;
            end else if (pending_valid) begin
              active_tw     <= pending_tw;
              pending_valid <= 1'b0;
            end
            if (burst_mode) remaining <= remaining - COUNT_WIDTH'(1);

            if (last_period) begin
              state     <= IDLE;
              acc       <= '0;
              interrupt <= 1'b1;
            end else if (state == STOPPING) begin
              state <= IDLE;
              acc   <= '0;
            end else begin
              acc <= sum[ACC_WIDTH-1:0];
              if (stop) state <= STOPPING;
            end
          end else begin
            acc <= sum[ACC_WIDTH-1:0];
            if (load) begin
              pending_tw    <= tuning_word;
              pending_valid <= 1'b1;
            end
            if (stop && state == RUN) state <= STOPPING;
          end
        end

        default: begin
          state <= IDLE;
          acc   <= '0;
        end
      endcase
    end
  end

endmodule
